// File: rtl/phy_tx_pkg.sv
// Shared types and constants for the PHY transmit lane scheduler.
// Link bring-up state encoding, default K-characters and lane count.
package phy_tx_pkg;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    localparam logic [7:0] IDLE_COM  = 8'hBC;
    localparam logic [7:0] SKIP_CHAR = 8'h1C;
    localparam int         NUM_LANES = 4;

endpackage

// File: rtl/phy_tx_lane_scheduler_rr_arbiter4.sv
// Purpose: combinational 4-way round-robin pick starting at rr_ptr.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter4 (
    input  logic [3:0] valid,
    input  logic [1:0] rr_ptr,
    output logic [1:0] grant,
    output logic       any_valid
);

    // Walk offsets from farthest to nearest so the nearest valid lane wins.
    always_comb begin
        grant     = rr_ptr;
        any_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (valid[rr_ptr + 2'(k)]) begin
                grant     = rr_ptr + 2'(k);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phy_tx_lane_scheduler.sv
// Purpose: link bring-up FSM plus round-robin byte scheduler feeding the TX serializer (SKIP_INSERT_EN adds periodic SKIP slots).
// Latency: one byte per BIT_CYCLES clk_32f cycles; load/ack pulse the cycle after each byte boundary.
// Backpressure: none upstream; a lane pops only when its one-cycle ack pulses, inputs are sampled at boundaries only.
module phy_tx_lane_scheduler #(
    parameter int         BIT_CYCLES    = 8,
    parameter int         SYNC_COUNT    = 4,
    parameter int         SKIP_INTERVAL = 16,
    parameter logic [7:0] SKIP_CHAR     = phy_tx_pkg::SKIP_CHAR
) (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] IDLE,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    output logic [7:0] data_out,
    output logic       data_k,
    output logic       load,
    output logic [1:0] lane_sel,
    output logic [3:0] ack,
    output logic       link_active
);
    import phy_tx_pkg::*;

    localparam int         BW        = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [1:0] ST_RESET  = RESET;
    localparam logic [1:0] ST_SYNC   = SYNC;
    localparam logic [1:0] ST_ACTIVE = ACTIVE;

    if (BIT_CYCLES < 2 || BIT_CYCLES > 16 || (BIT_CYCLES & (BIT_CYCLES - 1)) != 0) begin : g_bad_bit_cycles
        $error("BIT_CYCLES must be a power of two in 2..16");
    end
    if (SYNC_COUNT < 1 || SYNC_COUNT > 255) begin : g_bad_sync_count
        $error("SYNC_COUNT must be in 1..255");
    end
    if (SKIP_INTERVAL < 2) begin : g_bad_skip_interval
        $error("SKIP_INTERVAL must be at least 2");
    end

    logic [BW-1:0] bit_cnt;
    logic [7:0]    sync_cnt;
    logic [1:0]    rr_ptr;
    logic [1:0]    state;
    logic [1:0]    grant;
    logic          any_valid;
    logic          boundary;
    logic          skip_slot;
    logic [3:0]    lane_vld;
    logic [7:0]    lane_dat [NUM_LANES];

    assign boundary = (bit_cnt == BW'(BIT_CYCLES - 1));
    assign lane_vld = {valid_in3, valid_in2, valid_in1, valid_in0};
    assign lane_dat[0] = in0;
    assign lane_dat[1] = in1;
    assign lane_dat[2] = in2;
    assign lane_dat[3] = in3;

    rr_arbiter4 u_arb (
        .valid     (lane_vld),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

`ifdef SKIP_INSERT_EN
    logic [15:0] slot_cnt;

    assign skip_slot = (slot_cnt == 16'(SKIP_INTERVAL - 1));

    // Counts ACTIVE slots only; any boundary outside ACTIVE (or leaving it) restarts the spacing.
    always_ff @(posedge clk_32f or negedge rst) begin
        if (!rst) begin
            slot_cnt <= '0;
        end else if (boundary) begin
            if (state != ST_ACTIVE || !tx_en || skip_slot)
                slot_cnt <= '0;
            else
                slot_cnt <= slot_cnt + 16'd1;
        end
    end
`else
    assign skip_slot = 1'b0;
`endif

    always_ff @(posedge clk_32f or negedge rst) begin
        if (!rst) begin
            bit_cnt     <= '0;
            sync_cnt    <= '0;
            rr_ptr      <= '0;
            state       <= ST_RESET;
            data_out    <= '0;
            data_k      <= 1'b0;
            load        <= 1'b0;
            lane_sel    <= '0;
            ack         <= '0;
            link_active <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
            load    <= 1'b0;
            ack     <= '0;
            if (boundary) begin
                // Every byte defaults to the comma; only a granted payload slot overrides it.
                load     <= 1'b1;
                data_out <= IDLE;
                data_k   <= 1'b1;
                case (state)
                    ST_RESET: state <= ST_SYNC;
                    ST_SYNC: begin
                        if (!tx_en) begin
                            sync_cnt <= '0;
                        end else if (sync_cnt == 8'(SYNC_COUNT - 1)) begin
                            state       <= ST_ACTIVE;
                            link_active <= 1'b1;
                            sync_cnt    <= '0;
                        end else begin
                            sync_cnt <= sync_cnt + 8'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (!tx_en) begin
                            state       <= ST_SYNC;
                            link_active <= 1'b0;
                            sync_cnt    <= '0;
                        end else if (skip_slot) begin
                            data_out <= SKIP_CHAR;
                        end else if (any_valid) begin
                            data_out <= lane_dat[grant];
                            data_k   <= 1'b0;
                            lane_sel <= grant;
                            ack      <= 4'b0001 << grant;
                            rr_ptr   <= grant + 2'd1;
                        end
                    end
                    default: state <= ST_RESET;
                endcase
            end
        end
    end

endmodule

// File: doc/phy_tx_lane_scheduler.md
Name: phy_tx_lane_scheduler

Overview:
Sequencer in front of the PHY transmit serializer. Shares the single byte path between four lane sources (in0..in3 with valid_in0..3) by round-robin arbitration, one byte per byte period. Runs a link-bring-up state machine that sends the IDLE/comma character before payload. Drives the serializer with a registered byte plus a one-cycle load strobe, and returns one-cycle acks to the lane sources.

Parameters:
BIT_CYCLES, 8, clk_32f cycles per byte period (power of two, 2..16)
SYNC_COUNT, 4, IDLE bytes sent in SYNC before entering ACTIVE (1..255)
SKIP_INTERVAL, 16, payload-slot spacing of SKIP insertion (only with SKIP_INSERT_EN)
SKIP_CHAR, 8'h1C, K-character inserted as SKIP

Ports:
clk_32f  input  1  single clock for the whole block
rst  input  1  asynchronous, active-low reset
tx_en  input  1  link enable; sampled at byte boundary
IDLE  input  8  IDLE/comma character sent when no payload
in0..in3  input  8 each  lane payload bytes
valid_in0..valid_in3  input  1 each  lane has a byte ready
data_out  output  8  byte to serializer (registered)
data_k  output  1  data_out is a K-character (IDLE/SKIP)
load  output  1  one-cycle strobe: data_out valid for serializer
lane_sel  output  2  lane index of current payload byte
ack  output  4  one-hot, one-cycle pop strobe to lane i
link_active  output  1  high in ACTIVE state

Behaviour:
- Reset (rst=0, async): data_out=0, data_k=0, load=0, lane_sel=0, ack=0, link_active=0, bit_cnt=0, sync_cnt=0, rr_ptr=0, state=RESET. Reset mid-byte clears everything at once; no partial byte is completed.
- bit_cnt counts 0..BIT_CYCLES-1 and wraps. The byte boundary is the edge where bit_cnt==BIT_CYCLES-1.
- At each boundary, data_out, data_k, lane_sel and ack update and load is 1 for exactly the following cycle. load period is BIT_CYCLES. The first load occurs BIT_CYCLES cycles after rst rises.
- ack is high in the same cycle as load. A source pops its byte on ack. valid and in* are sampled only at boundaries.
- State RESET: at the first boundary, emit IDLE with data_k=1, then go to SYNC.
- State SYNC:
  - Each boundary emits IDLE with data_k=1 and increments sync_cnt.
  - After SYNC_COUNT IDLE bytes in SYNC, go to ACTIVE.
  - If tx_en=0, hold SYNC and reset sync_cnt to 0.
- State ACTIVE:
  - link_active=1.
  - Each boundary: scan lanes rr_ptr, rr_ptr+1, ... (mod 4). The first lane i with valid_in_i=1 wins: data_out=in_i, data_k=0, lane_sel=i, ack[i]=1, rr_ptr=(i+1) mod 4.
  - No valid lane: data_out=IDLE, data_k=1, ack=0, lane_sel and rr_ptr hold.
  - tx_en=0 at a boundary: emit IDLE, go to SYNC, sync_cnt=0, link_active drops the next cycle.
- Simultaneous valids: round-robin order only; a lane continuously valid gets at most every 4th grant when all four are valid.
- A valid that changes between boundaries is ignored.
- IDLE changes take effect at the next boundary.

Optional Feature:
SKIP_INSERT_EN
- Defined: in ACTIVE, a slot counter increments every boundary. When it reaches SKIP_INTERVAL-1, that slot emits SKIP_CHAR with data_k=1, no ack, rr_ptr held, and the counter wraps to 0. The counter is cleared on leaving ACTIVE and on reset.
- Undefined: no SKIP slots, no counter logic.

Decomposition:
- Package phy_tx_pkg holds:
  - state enum: RESET, SYNC, ACTIVE
  - default K-character constants: IDLE_COM=8'hBC, SKIP_CHAR=8'h1C
  - lane count constant NUM_LANES=4
- One natural sub-module, rr_arbiter4: combinational 4-way round-robin pick from valid vector and rr_ptr, returning grant index and any_valid.

Test Plan:
- Release rst, tx_en=1, IDLE=8'hBC, all valid=1, in0..3=AA,BB,CC,DD:
  - 1 RESET byte and 4 SYNC bytes of BC with k=1.
  - Then AA,BB,CC,DD,AA... with load every 8 cycles.
  - ack one-hot 1,2,4,8 in sequence.
- ACTIVE with only valid_in1 and valid_in3 = 1, in1=FF, in3=00 -> FF,00,FF,00 with lane_sel 1,3,1,3.
- ACTIVE with all valid=0, IDLE=8'h7C -> data_out=7C, k=1, ack=0, rr_ptr unchanged. Then valid_in2=1 -> next byte is in2.
- rst driven low 3 cycles into a byte period -> all outputs 0 immediately. After release, the first load follows 8 cycles later with BC in RESET/SYNC.
- tx_en dropped in ACTIVE -> next boundary emits IDLE and link_active=0. After tx_en returns, 4 IDLE bytes precede payload.
- With SKIP_INSERT_EN, all valid -> every 16th ACTIVE slot is 1C with k=1 and no ack; round-robin order continues unbroken around it.
